// File: rtl/multicycle_sequencer_if.sv
// Control bundle between the multi-cycle sequencer and the datapath / memory side.
// The slave modport is the sequencer; the master modport is whatever drives the IR fields.
interface multicycle_sequencer_if;
   logic [1:0] instr_type;
   logic [4:0] opcode;
   logic       stop_bit;
   logic       zero_signal;
   logic       mem_ready;
   logic [1:0] pc_src;
   logic       pc_write;
   logic       ir_write;
   logic       mem_rd;
   logic       mem_wr;
   logic       reg_write;
   logic [2:0] state_o;

   modport master (
      output instr_type, opcode, stop_bit, zero_signal, mem_ready,
      input  pc_src, pc_write, ir_write, mem_rd, mem_wr, reg_write, state_o
   );

   modport slave (
      input  instr_type, opcode, stop_bit, zero_signal, mem_ready,
      output pc_src, pc_write, ir_write, mem_rd, mem_wr, reg_write, state_o
   );
endinterface

// File: rtl/multicycle_sequencer.sv
// Main control FSM of the multi-cycle core: steps IF/ID/EX/MEM/WB and drives every
// state-dependent enable. Only the state is registered; all outputs are combinational.
module multicycle_sequencer #(
   parameter logic [4:0] OP_LW  = 5'b00010,
   parameter logic [4:0] OP_SW  = 5'b00011,
   parameter logic [4:0] OP_BEQ = 5'b00100
) (
   input logic             clk,
   input logic             reset,
   multicycle_sequencer_if.slave bus
);

   localparam logic [2:0] S_IF  = 3'd0;
   localparam logic [2:0] S_ID  = 3'd1;
   localparam logic [2:0] S_EX  = 3'd2;
   localparam logic [2:0] S_MEM = 3'd3;
   localparam logic [2:0] S_WB  = 3'd4;

   localparam logic [1:0] T_R = 2'b00;
   localparam logic [1:0] T_I = 2'b01;
   localparam logic [1:0] T_J = 2'b10;

   localparam logic [1:0] PC_SEQ = 2'b00;
   localparam logic [1:0] PC_BR  = 2'b01;
   localparam logic [1:0] PC_JMP = 2'b10;
   localparam logic [1:0] PC_RET = 2'b11;

   logic [2:0] state;
   logic [2:0] state_nxt;

   logic is_beq;
   logic is_load;
   logic is_store;

   assign is_beq   = (bus.instr_type == T_I) && (bus.opcode == OP_BEQ);
   assign is_load  = (bus.instr_type == T_I) && (bus.opcode == OP_LW);
   assign is_store = (bus.instr_type == T_I) && (bus.opcode == OP_SW);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= S_IF;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = S_IF;
      case (state)
         S_IF: begin
            state_nxt = bus.mem_ready ? S_ID : S_IF;
         end
         S_ID: begin
            if (bus.stop_bit || (bus.instr_type == T_J)) begin
               state_nxt = S_IF;
            end else begin
               state_nxt = S_EX;
            end
         end
         S_EX: begin
            if (is_beq) begin
               state_nxt = S_IF;
            end else if (is_load || is_store) begin
               state_nxt = S_MEM;
            end else if (bus.instr_type != T_J) begin
               state_nxt = S_WB;
            end else begin
               state_nxt = S_IF;
            end
         end
         S_MEM: begin
            // A MEM state with neither a load nor a store in the IR has nothing to wait for.
            if (!(is_load || is_store)) begin
               state_nxt = S_IF;
            end else if (bus.mem_ready) begin
               state_nxt = is_load ? S_WB : S_IF;
            end else begin
               state_nxt = S_MEM;
            end
         end
         S_WB: begin
            state_nxt = S_IF;
         end
         default: begin
            state_nxt = S_IF;
         end
      endcase
   end

   // Outputs are gated by reset so an access in flight is dropped the moment reset falls.
   always_comb begin
      bus.pc_src    = PC_SEQ;
      bus.pc_write  = 1'b0;
      bus.ir_write  = 1'b0;
      bus.mem_rd    = 1'b0;
      bus.mem_wr    = 1'b0;
      bus.reg_write = 1'b0;
      if (reset) begin
         case (state)
            S_IF: begin
               bus.mem_rd   = 1'b1;
               bus.ir_write = bus.mem_ready;
               bus.pc_write = bus.mem_ready;
            end
            S_ID: begin
               if (bus.stop_bit) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = PC_RET;
               end else if (bus.instr_type == T_J) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = PC_JMP;
               end
            end
            S_EX: begin
               if (is_beq && bus.zero_signal) begin
                  bus.pc_write = 1'b1;
                  bus.pc_src   = PC_BR;
               end
            end
            S_MEM: begin
               bus.mem_rd = is_load;
               bus.mem_wr = is_store;
            end
            S_WB: begin
               bus.reg_write = 1'b1;
            end
            default: begin
               bus.pc_src = PC_SEQ;
            end
         endcase
      end
   end

   assign bus.state_o = state;

   // Unused-type guard: R type never redirects the PC from EX.
   logic unused_r;
   assign unused_r = (bus.instr_type == T_R) & 1'b0;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed, table-driven bench for the multi-cycle control sequencer.
module tb_multicycle_sequencer;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   multicycle_sequencer_if bus ();

   multicycle_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] typ;
      logic [4:0] op;
      logic       stop;
      logic       zero;
      logic       mr;
      logic [9:0] exp;
   } vec_t;

   vec_t vecs[$];

   // {state, pc_src, pc_write, ir_write, mem_rd, mem_wr, reg_write}
   function automatic logic [9:0] ex(input logic [2:0] st, input logic [1:0] src,
                                     input logic pcw, input logic irw, input logic rd,
                                     input logic wr, input logic rw);
      return {st, src, pcw, irw, rd, wr, rw};
   endfunction

   function automatic logic [9:0] observed();
      return {bus.state_o, bus.pc_src, bus.pc_write, bus.ir_write,
              bus.mem_rd, bus.mem_wr, bus.reg_write};
   endfunction

   task automatic add(input logic [1:0] typ, input logic [4:0] op, input logic stop,
                      input logic zero, input logic mr, input logic [9:0] exp);
      vec_t v;
      v.typ = typ; v.op = op; v.stop = stop; v.zero = zero; v.mr = mr; v.exp = exp;
      vecs.push_back(v);
   endtask

   task automatic drive(input logic [1:0] typ, input logic [4:0] op, input logic stop,
                        input logic zero, input logic mr);
      bus.instr_type  = typ;
      bus.opcode      = op;
      bus.stop_bit    = stop;
      bus.zero_signal = zero;
      bus.mem_ready   = mr;
   endtask

   task automatic check(input string name, input logic [9:0] exp);
      logic [9:0] got;
      got = observed();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got st/src/pcw/irw/rd/wr/rw=%b expected %b", name, got, exp);
      end
   endtask

   logic [9:0] fetch_e;
   logic [9:0] idle_id;
   logic [9:0] idle_ex;
   logic [9:0] wb_e;

   initial begin
      checks   = 0;
      failures = 0;
      fetch_e  = ex(3'd0, 2'b00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      idle_id  = ex(3'd1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      idle_ex  = ex(3'd2, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      wb_e     = ex(3'd4, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

      // R-type, mem_ready held high throughout
      add(2'b00, 5'd0, 0, 0, 1, fetch_e);
      add(2'b00, 5'd0, 0, 0, 1, idle_id);
      add(2'b00, 5'd0, 0, 0, 1, idle_ex);
      add(2'b00, 5'd0, 0, 0, 1, wb_e);
      // I-type ALU with one fetch wait cycle
      add(2'b01, 5'd1, 0, 0, 0, ex(3'd0, 2'b00, 0, 0, 1, 0, 0));
      add(2'b01, 5'd1, 0, 0, 1, fetch_e);
      add(2'b01, 5'd1, 0, 0, 0, idle_id);
      add(2'b01, 5'd1, 0, 1, 0, idle_ex);
      add(2'b01, 5'd1, 0, 0, 0, wb_e);
      // BEQ taken
      add(2'b01, 5'd4, 0, 1, 1, fetch_e);
      add(2'b01, 5'd4, 0, 1, 1, idle_id);
      add(2'b01, 5'd4, 0, 1, 1, ex(3'd2, 2'b01, 1, 0, 0, 0, 0));
      // BEQ not taken
      add(2'b01, 5'd4, 0, 0, 1, fetch_e);
      add(2'b01, 5'd4, 0, 0, 1, idle_id);
      add(2'b01, 5'd4, 0, 0, 1, idle_ex);
      // LW with two MEM wait cycles
      add(2'b01, 5'd2, 0, 0, 1, fetch_e);
      add(2'b01, 5'd2, 0, 0, 0, idle_id);
      add(2'b01, 5'd2, 0, 0, 0, idle_ex);
      add(2'b01, 5'd2, 0, 0, 0, ex(3'd3, 2'b00, 0, 0, 1, 0, 0));
      add(2'b01, 5'd2, 0, 0, 0, ex(3'd3, 2'b00, 0, 0, 1, 0, 0));
      add(2'b01, 5'd2, 0, 0, 1, ex(3'd3, 2'b00, 0, 0, 1, 0, 0));
      add(2'b01, 5'd2, 0, 0, 0, wb_e);
      // SW, no wait
      add(2'b01, 5'd3, 0, 0, 1, fetch_e);
      add(2'b01, 5'd3, 0, 0, 1, idle_id);
      add(2'b01, 5'd3, 0, 0, 1, idle_ex);
      add(2'b01, 5'd3, 0, 0, 1, ex(3'd3, 2'b00, 0, 0, 0, 1, 0));
      // Jump, then jump with stop, then R-type with stop
      add(2'b10, 5'd0, 0, 0, 1, fetch_e);
      add(2'b10, 5'd0, 0, 0, 1, ex(3'd1, 2'b10, 1, 0, 0, 0, 0));
      add(2'b10, 5'd0, 1, 0, 1, fetch_e);
      add(2'b10, 5'd0, 1, 0, 1, ex(3'd1, 2'b11, 1, 0, 0, 0, 0));
      add(2'b00, 5'd0, 1, 0, 1, fetch_e);
      add(2'b00, 5'd0, 1, 0, 1, ex(3'd1, 2'b11, 1, 0, 0, 0, 0));
      // Special type goes through WB
      add(2'b11, 5'd5, 0, 0, 1, fetch_e);
      add(2'b11, 5'd5, 0, 0, 1, idle_id);
      add(2'b11, 5'd5, 0, 0, 1, idle_ex);
      add(2'b11, 5'd5, 0, 0, 1, wb_e);
      // Back in IF, waiting
      add(2'b00, 5'd0, 0, 0, 0, ex(3'd0, 2'b00, 0, 0, 1, 0, 0));

      // Reset held low three cycles, mem_ready high to show it is ignored
      reset = 1'b0;
      drive(2'b00, 5'd0, 1'b0, 1'b0, 1'b1);
      repeat (3) begin
         @(negedge clk);
         #1 check("reset_low", 10'b0);
      end
      @(negedge clk);
      reset = 1'b1;
      drive(2'b00, 5'd0, 1'b0, 1'b0, 1'b0);
      #1 check("first_fetch_after_release", ex(3'd0, 2'b00, 0, 0, 1, 0, 0));

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].typ, vecs[i].op, vecs[i].stop, vecs[i].zero, vecs[i].mr);
         #1 check($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Reset during a stalled store: mem_wr must drop without a clock edge
      @(negedge clk);
      drive(2'b01, 5'd3, 1'b0, 1'b0, 1'b1);
      #1 check("sw_fetch", fetch_e);
      @(negedge clk);
      #1 check("sw_id", idle_id);
      @(negedge clk);
      #1 check("sw_ex", idle_ex);
      @(negedge clk);
      bus.mem_ready = 1'b0;
      #1 check("sw_mem_stall", ex(3'd3, 2'b00, 0, 0, 0, 1, 0));
      #1 reset = 1'b0;
      #1 check("sw_reset_async", 10'b0);
      @(negedge clk);
      #1 check("sw_reset_held", 10'b0);
      @(negedge clk);
      reset = 1'b1;
      #1 check("sw_refetch_after_release", ex(3'd0, 2'b00, 0, 0, 1, 0, 0));
      @(negedge clk);
      bus.mem_ready = 1'b1;
      #1 check("refetch_completes", fetch_e);
      @(negedge clk);
      #1 check("refetch_id", idle_id);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
